task_graph_mapper: RTL
======================

Name: task_graph_mapper

Overview:
- Parametrised next generation of task_mapper.
- Ingests an application task graph as a stream of adjacency-matrix entries (row, col, weight) under a valid/ready handshake, and accumulates a per-task communication weight.
- Detects the root task, then greedily maps every task onto NUM_PE processing elements by least accumulated load.
- Emits one (task, PE) assignment per handshake and returns to ingest for the next application.

Parameters:
- NUM_V, 4: number of tasks (vertices); any value >= 2.
- W, 32: edge-weight width (task_array).
- NUM_PE, 4: number of processing elements; any value >= 1.
- ACC_W, 40: accumulator width for task weights and PE loads; must be >= W.
- IDX_W, $clog2(NUM_V): width of row, col, task ids.
- PE_W, max(1,$clog2(NUM_PE)): width of PE id.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  entry valid
- in_ready  out  1  entry accepted when in_valid&in_ready
- task_array  in  W  edge weight; 0 = no edge
- row  in  IDX_W  source task
- col  in  IDX_W  destination task
- app_end  in  1  one-cycle pulse, last entry of application seen
- map_valid  out  1  assignment valid
- map_ready  in  1  consumer accepts assignment
- map_task  out  IDX_W  task id
- map_pe  out  PE_W  assigned PE
- map_load  out  ACC_W  PE load after this assignment
- map_root  out  1  map_task is the root task
- root_found  out  1  a nonzero entry was seen this application
- root_id  out  IDX_W  root task id
- done  out  1  one-cycle pulse after last assignment accepted

Behaviour:
- Reset (any state, including mid-MAP/EMIT):
  - state=LOAD; all tw[] and pe_load[] cleared.
  - map_valid=0, done=0, root_found=0, root_id=0, map_task=0, map_pe=0, map_load=0, map_root=0.
  - in_ready=1 from the first cycle after rst deasserts.
- States are LOAD, MAP, EMIT, DONE. in_ready=1 only in LOAD.
- LOAD, on each accepted entry:
  - Ignore the entry if task_array==0, row==col, or row/col >= NUM_V.
  - Otherwise tw[row] += task_array, saturating at 2^ACC_W-1. Only row accumulates; the stream carries both (i,j) and (j,i).
  - On the first counted entry: root_found=1, root_id=row.
- app_end in LOAD: an entry accepted in the same cycle is counted first; next state is MAP. app_end outside LOAD is ignored.
- Mapping order:
  - If root_found: root first, then remaining tasks ascending, skipping root.
  - Otherwise: 0..NUM_V-1.
  - Every task is mapped, zero-weight tasks included.
- MAP (1 cycle) registers the assignment for the current task t:
  - pe = argmin pe_load[]; ties go to the lowest PE index.
  - map_task=t, map_pe=pe, map_load=sat(pe_load[pe]+tw[t]), map_root=(root_found && t==root_id).
  - Next state is EMIT.
- EMIT:
  - map_valid=1; all map_* outputs held stable until map_ready.
  - On handshake: pe_load[map_pe]=map_load; map_valid=0 next cycle.
  - Next state is MAP if tasks remain, else DONE.
- DONE (1 cycle):
  - done=1; clear tw[], pe_load[], root_found, root_id.
  - Next state is LOAD.
- Latency:
  - app_end at cycle N gives first map_valid at N+2.
  - With map_ready tied high, successive assignments are 2 cycles apart.
  - done asserts the cycle after the last handshake; in_ready returns the cycle after that.
- map_valid never asserts in LOAD or DONE.
- root_found/root_id stay valid from detection through EMIT of the last task.

Test Plan:
- NUM_V=4, NUM_PE=2; stream 16 entries row-major with [0][1]=[1][0]=5, [1][2]=[2][1]=6, [0][3]=[3][0]=7, rest 0; then app_end:
  - root_id=0.
  - Assignments (task,pe,load) = (0,0,12) (1,1,11) (2,1,17) (3,0,19); map_root=1 only on task 0; done pulses once.
- Same graph with NUM_PE=4 -> (0,0,12) (1,1,11) (2,2,6) (3,3,7).
- Only edge 2-3 weight 9, NUM_PE=2:
  - root_id=2; order 2,0,1,3.
  - Assignments -> (2,0,9) (0,1,0) (1,1,0) (3,1,9).
- All-zero matrix:
  - root_found=0; order 0..3.
  - All assignments to PE0 with load 0; done asserts.
- Backpressure:
  - map_ready low 3 cycles during first EMIT -> map_* held constant, in_ready=0.
  - Then map_ready=1 -> sequence continues unchanged.
- W=8, ACC_W=8:
  - Row 0 entries 200 and 100 -> tw0=255 saturated.
  - Diagonal entry [2][2]=50 ignored.
- rst asserted during second EMIT -> next cycle map_valid=0, in_ready=1, root_found=0; rerunning the first scenario reproduces identical results.

Source files
------------

// File: rtl/task_graph_mapper.sv
// task_graph_mapper: accumulates per-task edge weight from a streamed adjacency matrix, then greedily maps tasks to least-loaded PEs
module task_graph_mapper #(
   parameter int NUM_V  = 4,
   parameter int W      = 32,
   parameter int NUM_PE = 4,
   parameter int ACC_W  = 40,
   parameter int IDX_W  = $clog2(NUM_V),
   parameter int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     task_array,
   input  logic [IDX_W-1:0] row,
   input  logic [IDX_W-1:0] col,
   input  logic             app_end,
   output logic             map_valid,
   input  logic             map_ready,
   output logic [IDX_W-1:0] map_task,
   output logic [PE_W-1:0]  map_pe,
   output logic [ACC_W-1:0] map_load,
   output logic             map_root,
   output logic             root_found,
   output logic [IDX_W-1:0] root_id,
   output logic             done
);
   typedef enum logic [1:0] {LOAD, MAP, EMIT, DONE} state_t;
   localparam logic [ACC_W-1:0] ACC_MAX = '1;
   state_t state;
   logic [ACC_W-1:0] tw [NUM_V];
   logic [ACC_W-1:0] pe_load [NUM_PE];
   logic [IDX_W-1:0] k, cur;
   logic [PE_W-1:0] min_pe;
   logic [ACC_W-1:0] min_load, in_acc, map_acc;
   logic [ACC_W:0] in_sum, map_sum;
   logic hit;

   assign in_ready = state == LOAD;

   // an entry counts only as a real off-diagonal edge between existing tasks; row weight saturates
   always_comb begin
      hit = in_valid && task_array != '0 && row != col && 32'(row) < NUM_V && 32'(col) < NUM_V;
      in_sum = {1'b0, tw[row]} + (ACC_W+1)'(task_array);
      in_acc = in_sum[ACC_W] ? ACC_MAX : in_sum[ACC_W-1:0];
   end

   // root goes first, the rest ascend around it; least-loaded PE wins with ties to the lowest index
   always_comb begin
      cur = !root_found ? k : (k == '0) ? root_id : (k - 1'b1 < root_id) ? k - 1'b1 : k;
      min_pe = '0;
      min_load = pe_load[0];
      for (int p = 1; p < NUM_PE; p++)
         if (pe_load[p] < min_load) begin
            min_pe = PE_W'(p);
            min_load = pe_load[p];
         end
      map_sum = {1'b0, min_load} + {1'b0, tw[cur]};
      map_acc = map_sum[ACC_W] ? ACC_MAX : map_sum[ACC_W-1:0];
   end

   // ingest, compute one assignment, hold it until accepted, then pulse done and clear for the next app
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         for (int i = 0; i < NUM_V; i++) tw[i] <= '0;
         for (int i = 0; i < NUM_PE; i++) pe_load[i] <= '0;
         k <= '0;
         map_valid <= 1'b0;
         done <= 1'b0;
         root_found <= 1'b0;
         root_id <= '0;
         map_task <= '0;
         map_pe <= '0;
         map_load <= '0;
         map_root <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            LOAD: begin
               if (hit) begin
                  tw[row] <= in_acc;
                  if (!root_found) begin
                     root_found <= 1'b1;
                     root_id <= row;
                  end
               end
               if (app_end) begin
                  state <= MAP;
                  k <= '0;
               end
            end
            MAP: begin
               map_task <= cur;
               map_pe <= min_pe;
               map_load <= map_acc;
               map_root <= root_found && cur == root_id;
               map_valid <= 1'b1;
               state <= EMIT;
            end
            EMIT: begin
               if (map_ready) begin
                  pe_load[map_pe] <= map_load;
                  map_valid <= 1'b0;
                  k <= k + 1'b1;
                  done <= k == IDX_W'(NUM_V - 1);
                  state <= (k == IDX_W'(NUM_V - 1)) ? DONE : MAP;
               end
            end
            DONE: begin
               for (int i = 0; i < NUM_V; i++) tw[i] <= '0;
               for (int i = 0; i < NUM_PE; i++) pe_load[i] <= '0;
               root_found <= 1'b0;
               root_id <= '0;
               state <= LOAD;
            end
         endcase
      end
   end
endmodule
